// File: rtl/power_pipe.sv
// power_pipe: raises an unsigned operand to the power 2^m using up to STAGES chained squarings.
// Latency: STAGES cycles from acceptance for every m; sustains one beat per cycle.
// Backpressure: the whole pipe freezes while a result waits (o_valid & !i_ready); o_ready mirrors that.
module power_pipe #(
    parameter int IN_W   = 32,
    parameter int OUT_W  = 64,
    parameter int STAGES = 3,
    parameter bit SAT    = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [IN_W-1:0]  i_value,
    input  logic [2:0]       i_mode,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [OUT_W-1:0] o_power,
    output logic             o_overflow
);
    localparam logic [2:0] MAX_M = 3'(STAGES);

    logic                 en;
    logic [STAGES-1:0]    vld_q, ovf_q, vld_d, ovf_d;
    logic [OUT_W-1:0]     val_q [STAGES];
    logic [OUT_W-1:0]     val_d [STAGES];
    logic [2:0]           cnt_q [STAGES];
    logic [2:0]           cnt_d [STAGES];

    // Inputs seen by each stage: stage 0 takes the new beat, stage k takes stage k-1's register.
    logic [STAGES-1:0]    src_vld, src_ovf;
    logic [OUT_W-1:0]     src_val [STAGES];
    logic [2:0]           src_cnt [STAGES];
    logic [2*OUT_W-1:0]   sq      [STAGES];

    assign en         = !vld_q[STAGES-1] || i_ready;
    assign o_ready    = en;
    assign o_valid    = vld_q[STAGES-1];
    assign o_power    = val_q[STAGES-1];
    assign o_overflow = ovf_q[STAGES-1];

    always_comb begin
        src_vld[0] = i_valid;
        src_ovf[0] = 1'b0;
        src_val[0] = OUT_W'(i_value);
        src_cnt[0] = (i_mode > MAX_M) ? MAX_M : i_mode;
        for (int k = 1; k < STAGES; k++) begin
            src_vld[k] = vld_q[k-1];
            src_ovf[k] = ovf_q[k-1];
            src_val[k] = val_q[k-1];
            src_cnt[k] = cnt_q[k-1];
        end
    end

    // Stage k squares only while the beat still needs more than k squarings.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            sq[k]    = {{OUT_W{1'b0}}, src_val[k]} * {{OUT_W{1'b0}}, src_val[k]};
            vld_d[k] = src_vld[k];
            val_d[k] = src_val[k];
            cnt_d[k] = src_cnt[k];
            ovf_d[k] = src_ovf[k];
            if (src_cnt[k] > 3'(k)) begin
                val_d[k] = sq[k][OUT_W-1:0];
                if (|sq[k][2*OUT_W-1:OUT_W]) begin
                    ovf_d[k] = 1'b1;
                    if (SAT) begin
                        val_d[k] = '1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            ovf_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                val_q[k] <= '0;
                cnt_q[k] <= '0;
            end
        end else if (en) begin
            vld_q <= vld_d;
            ovf_q <= ovf_d;
            for (int k = 0; k < STAGES; k++) begin
                val_q[k] <= val_d[k];
                cnt_q[k] <= cnt_d[k];
            end
        end
    end
endmodule

// File: tb/tb_power_pipe.sv
// Bench for power_pipe: a truncating and a saturating instance share stimulus; a queue-based
// exact-arithmetic model scores every delivered beat, plus table vectors and reset/stall sequences.
module tb_power_pipe;
    localparam int STAGES = 3;

    logic        clk     = 1'b0;
    logic        reset   = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_ready = 1'b1;
    logic [31:0] i_value = '0;
    logic [2:0]  i_mode  = '0;
    logic        o_ready0, o_valid0, o_ovf0;
    logic        o_ready1, o_valid1, o_ovf1;
    logic [63:0] o_pow0, o_pow1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int ovf_seen = 0;
    bit chk_lat = 1'b0;

    typedef struct {
        logic [63:0] pow;
        logic [63:0] pow_sat;
        logic        ovf;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0] v;
        logic [2:0]  m;
        logic [63:0] pow;
        logic        ovf;
    } vec_t;

    exp_t        exp_q[$];
    logic [63:0] out_log[$];
    vec_t        tbl[12];

    bit          hold_prev = 1'b0;
    logic [63:0] held_pow;
    logic        held_ovf;

    power_pipe #(.IN_W(32), .OUT_W(64), .STAGES(STAGES), .SAT(1'b0)) dut_trunc (
        .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(o_ready0),
        .i_value(i_value), .i_mode(i_mode), .o_valid(o_valid0), .i_ready(i_ready),
        .o_power(o_pow0), .o_overflow(o_ovf0)
    );

    power_pipe #(.IN_W(32), .OUT_W(64), .STAGES(STAGES), .SAT(1'b1)) dut_sat (
        .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(o_ready1),
        .i_value(i_value), .i_mode(i_mode), .o_valid(o_valid1), .i_ready(i_ready),
        .o_power(o_pow1), .o_overflow(o_ovf1)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, req);
        end
    endtask

    // Exact v^(2^m) in wide arithmetic; the 64-bit view and overflow follow from the full product.
    function automatic exp_t model(input logic [31:0] v, input logic [2:0] m);
        exp_t         e;
        logic [263:0] x;
        int           mm;
        mm = (int'(m) > STAGES) ? STAGES : int'(m);
        x  = 264'd1;
        for (int i = 0; i < (1 << mm); i++) x = x * {232'd0, v};
        e.ovf     = |x[263:64];
        e.pow     = x[63:0];
        e.pow_sat = e.ovf ? 64'hFFFF_FFFF_FFFF_FFFF : x[63:0];
        e.cyc     = cyc;
        return e;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset) begin
            exp_q.delete();
            hold_prev = 1'b0;
        end else begin
            chk1("o_ready", o_ready0, !o_valid0 || i_ready);
            chk1("o_ready_sat", o_ready1, !o_valid1 || i_ready);
            if (hold_prev) begin
                chk1("hold_valid", o_valid0, 1'b1);
                chk64("hold_power", o_pow0, held_pow);
                chk1("hold_ovf", o_ovf0, held_ovf);
            end
            if (o_valid0 && i_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got 0x%0h, expected no result", o_pow0);
                end else begin
                    e = exp_q.pop_front();
                    chk64("power", o_pow0, e.pow);
                    chk1("overflow", o_ovf0, e.ovf);
                    chk1("sat_valid", o_valid1, 1'b1);
                    chk64("sat_power", o_pow1, e.pow_sat);
                    chk1("sat_overflow", o_ovf1, e.ovf);
                    if (chk_lat) chk64("latency", 64'(cyc - e.cyc), 64'(STAGES));
                    out_log.push_back(o_pow0);
                    if (o_ovf0) ovf_seen++;
                end
            end
            if (i_valid && o_ready0) exp_q.push_back(model(i_value, i_mode));
            hold_prev = o_valid0 && !i_ready;
            held_pow  = o_pow0;
            held_ovf  = o_ovf0;
        end
    end

    task automatic wait_drain();
        for (int n = 0; n < 200; n++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk); #1;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d beats pending, expected 0", exp_q.size());
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk1({tag, "_valid"}, o_valid0, 1'b0);
        chk64({tag, "_power"}, o_pow0, 64'd0);
        chk1({tag, "_ovf"}, o_ovf0, 1'b0);
        chk1({tag, "_ready"}, o_ready0, 1'b1);
        chk1({tag, "_sat_valid"}, o_valid1, 1'b0);
        chk64({tag, "_sat_power"}, o_pow1, 64'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bit          got;
        bit          acc;
        int          sent;
        logic [63:0] x;

        tbl[0]  = '{32'd5, 3'd0, 64'd5, 1'b0};
        tbl[1]  = '{32'd5, 3'd1, 64'd25, 1'b0};
        tbl[2]  = '{32'd5, 3'd2, 64'd625, 1'b0};
        tbl[3]  = '{32'd5, 3'd3, 64'd390625, 1'b0};
        tbl[4]  = '{32'd5, 3'd7, 64'd390625, 1'b0};
        tbl[5]  = '{32'd5, 3'd4, 64'd390625, 1'b0};
        tbl[6]  = '{32'd255, 3'd3, 64'd17878103347812890625, 1'b0};
        tbl[7]  = '{32'd256, 3'd3, 64'd0, 1'b1};
        tbl[8]  = '{32'hFFFF_FFFF, 3'd0, 64'h0000_0000_FFFF_FFFF, 1'b0};
        tbl[9]  = '{32'hFFFF_FFFF, 3'd1, 64'hFFFF_FFFE_0000_0001, 1'b0};
        tbl[10] = '{32'hFFFF_FFFF, 3'd2, 64'hFFFF_FFFC_0000_0001, 1'b1};
        tbl[11] = '{32'd0, 3'd3, 64'd0, 1'b0};

        // Reset raised between clock edges must clear outputs at once.
        #2 reset = 1'b1;
        #1 chk_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Table vectors, one beat at a time.
        foreach (tbl[i]) begin
            i_value = tbl[i].v;
            i_mode  = tbl[i].m;
            i_valid = 1'b1;
            @(posedge clk); #1;
            i_valid = 1'b0;
            got = 1'b0;
            for (int n = 0; n < 10; n++) begin
                if (o_valid0) begin
                    got = 1'b1;
                    break;
                end
                @(posedge clk); #1;
            end
            chk1("tbl_arrived", got, 1'b1);
            chk64("tbl_power", o_pow0, tbl[i].pow);
            chk1("tbl_ovf", o_ovf0, tbl[i].ovf);
            chk64("tbl_sat_power", o_pow1, tbl[i].ovf ? 64'hFFFF_FFFF_FFFF_FFFF : tbl[i].pow);
            chk1("tbl_sat_ovf", o_ovf1, tbl[i].ovf);
        end
        wait_drain();

        // Back-to-back streaming, m=3, with latency tracking.
        out_log.delete();
        ovf_seen = 0;
        chk_lat  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            i_value = 32'(i);
            i_mode  = 3'd3;
            i_valid = 1'b1;
            @(posedge clk); #1;
        end
        i_valid = 1'b0;
        wait_drain();
        chk_lat = 1'b0;
        chk64("stream_count", 64'(out_log.size()), 64'd100);
        if (out_log.size() == 100) begin
            chk64("stream_3", out_log[3], 64'd6561);
            chk64("stream_99", out_log[99], 64'd9227446944279201);
        end
        chk64("stream_ovf_seen", 64'(ovf_seen), 64'd0);

        // Backpressure: downstream stalls for 4 cycles mid-stream.
        out_log.delete();
        sent = 0;
        for (int t = 0; t < 40 && sent < 10; t++) begin
            i_ready = !(t >= 5 && t < 9);
            i_valid = 1'b1;
            i_value = 32'(1000 + sent);
            i_mode  = 3'd2;
            #1;
            if (!i_ready) chk1("stall_o_ready", o_ready0, 1'b0);
            acc = o_ready0;
            @(posedge clk); #1;
            if (acc) sent++;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        wait_drain();
        chk64("bp_count", 64'(out_log.size()), 64'd10);
        for (int i = 0; i < 10 && i < out_log.size(); i++) begin
            x = 64'(1000 + i);
            chk64("bp_order", out_log[i], x * x * x * x);
        end

        // Randomised traffic against the model.
        for (int t = 0; t < 400; t++) begin
            i_valid = ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 3) != 0);
            i_value = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 300));
            i_mode  = 3'($urandom_range(0, 7));
            @(posedge clk); #1;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        wait_drain();

        // Reset with two beats in flight, then a fresh beat right after release.
        i_value = 32'd7;
        i_mode  = 3'd3;
        i_valid = 1'b1;
        @(posedge clk); #1;
        i_value = 32'd8;
        @(posedge clk); #1;
        i_valid = 1'b0;
        @(posedge clk); #1;
        chk1("pre_reset_valid", o_valid0, 1'b1);
        reset = 1'b1;
        #1 chk_reset_outputs("midreset");
        @(posedge clk); #1;
        reset   = 1'b0;
        i_value = 32'd2;
        i_mode  = 3'd3;
        i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        chk1("post_reset_valid_1", o_valid0, 1'b0);
        @(posedge clk); #1;
        chk1("post_reset_valid_2", o_valid0, 1'b0);
        @(posedge clk); #1;
        chk1("post_reset_valid_3", o_valid0, 1'b1);
        chk64("post_reset_power", o_pow0, 64'd256);
        chk1("post_reset_ovf", o_ovf0, 1'b0);
        wait_drain();
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/power_pipe.md
POWER_PIPE -- requirements
Module: power_pipe

Interface
REQ-001 SHALL have parameter IN_W, default 32, meaning input operand width.
REQ-002 SHALL have parameter OUT_W, default 64, meaning result width (OUT_W >= IN_W).
REQ-003 SHALL have parameter STAGES, default 3, range 1..7, meaning number of squaring stages (max exponent 2^STAGES).
REQ-004 SHALL have parameter SAT, default 0, meaning overflow policy: 0 truncate, 1 saturate to all-ones.
REQ-005 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port i_valid  input  1  input beat valid.
REQ-008 SHALL have port o_ready  output  1  block accepts input this cycle.
REQ-009 SHALL have port i_value  input  IN_W  operand, unsigned.
REQ-010 SHALL have port i_mode  input  3  squaring count m for this beat (exponent 2^m).
REQ-011 SHALL have port o_valid  output  1  result beat valid.
REQ-012 SHALL have port i_ready  input  1  downstream accepts result this cycle.
REQ-013 SHALL have port o_power  output  OUT_W  result i_value^(2^m).
REQ-014 SHALL have port o_overflow  output  1  result exceeded OUT_W bits for this beat.

Function
REQ-015 SHALL implement a STAGES-deep pipeline; each stage holds valid, value (OUT_W), remaining-count and overflow bits.
REQ-016 SHALL define advance enable en = !o_valid | i_ready; all stages shift together when en=1 and hold every register when en=0.
REQ-017 SHALL drive o_ready = en combinationally; a beat is accepted iff i_valid & o_ready at a rising edge.
REQ-018 SHALL zero-extend i_value to OUT_W at stage 1 input.
REQ-019 SHALL clamp i_mode values > STAGES to STAGES on entry.
REQ-020 SHALL, in stage k (1..STAGES), square the value iff beat's effective m >= k, else pass it unchanged.
REQ-021 SHALL compute each square at 2*OUT_W bits, keep low OUT_W bits, and set stage overflow if any upper bit is nonzero.
REQ-022 SHALL OR overflow forward through stages, so o_overflow reflects any stage overflow of that beat.
REQ-023 SHALL, with SAT=1, force the value to all-ones at the overflowing stage and keep it all-ones through later stages; SAT=0 keeps truncated value.
REQ-024 SHALL have fixed latency STAGES cycles from acceptance to o_valid when i_ready stays 1, independent of m.
REQ-025 SHALL sustain one beat per cycle with i_valid=1 and i_ready=1 continuously.
REQ-026 SHALL hold o_valid, o_power, o_overflow stable while o_valid=1 and i_ready=0.
REQ-027 SHALL insert a bubble (valid 0) into stage 1 when en=1 and i_valid=0; bubbles carry no data obligations.
REQ-028 SHALL never drop, duplicate or reorder beats under any i_valid/i_ready pattern.
REQ-029 SHALL give o_power=i_value for m=0 (exponent 1).

Reset
REQ-030 SHALL, on reset assertion, immediately clear all stage valid, value, count and overflow registers to 0 without waiting for clk.
REQ-031 SHALL drive o_valid=0, o_power=0, o_overflow=0 during reset; o_ready=1 (since o_valid=0).
REQ-032 SHALL discard all in-flight beats on reset mid-operation; no result of a pre-reset beat appears after deassertion.
REQ-033 SHALL accept a new beat on the first rising edge after reset deasserts.

Verification (defaults IN_W=32, OUT_W=64, STAGES=3, SAT=0)
REQ-034 SHALL check reset: assert reset between edges -> o_valid=0, o_power=0, o_overflow=0 immediately, o_ready=1.
REQ-035 SHALL check streaming: i_value=0..99 back-to-back, m=3, i_ready=1 -> 100 results in order, 3-cycle latency, e.g. 3->6561, 99->9227446944279201, overflow 0.
REQ-036 SHALL check modes: i_value=5 with m=0,1,2,3,7 -> 5, 25, 625, 390625, 390625 (clamped).
REQ-037 SHALL check backpressure: stream 10 beats, i_ready=0 for 4 cycles mid-stream -> outputs held, o_ready=0 while stalled, all 10 results delivered exactly once in order.
REQ-038 SHALL check overflow: 255, m=3 -> 17878103347812890625, overflow 0; 256, m=3 -> 0, overflow 1; same with SAT=1 -> 0xFFFFFFFFFFFFFFFF, overflow 1.
REQ-039 SHALL check reset mid-stream: reset asserted with 2 beats in flight -> o_valid=0, no stale result afterwards; next beat 2, m=3 -> 256 after 3 cycles.
